// File: rtl/bsg_link_pkg.sv
// Shared helpers for the SDR upstream link: credit counter sizing, token increment and
// beat-slice addressing.
package bsg_link_pkg;

    // One extra bit so the counter can hold the full 2**lg_fifo_depth credit count.
    function automatic int unsigned credit_width(input int unsigned lg_fifo_depth);
        return lg_fifo_depth + 1;
    endfunction

    function automatic int unsigned token_increment(input int unsigned lg_decimation);
        return 32'd1 << lg_decimation;
    endfunction

    function automatic int unsigned slice_lsb(input int unsigned beat,
                                              input int unsigned channel,
                                              input int unsigned num_channels,
                                              input int unsigned channel_width);
        return (beat * num_channels + channel) * channel_width;
    endfunction

endpackage

// File: rtl/bsg_link_credit_counter.sv
// Per-channel credit counter: detects token toggles, adds the decimated credit return,
// subtracts issued beats and saturates at the receiver FIFO depth.
module bsg_link_credit_counter
    import bsg_link_pkg::*;
#(
    parameter int unsigned lg_fifo_depth_p                 = 6,
    parameter int unsigned lg_credit_to_token_decimation_p = 3
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic token_i,
    input  logic issue_i,
    output logic avail_o,
    output logic overflow_o
);

    localparam int unsigned cw_lp   = credit_width(lg_fifo_depth_p);
    localparam int unsigned max_lp  = 32'd1 << lg_fifo_depth_p;
    localparam int unsigned incr_lp = token_increment(lg_credit_to_token_decimation_p);

    localparam logic [cw_lp-1:0] max_credit = cw_lp'(max_lp);
    localparam logic [cw_lp+1:0] max_wide   = (cw_lp + 2)'(max_lp);
    localparam logic [cw_lp+1:0] incr_wide  = (cw_lp + 2)'(incr_lp);

    logic [cw_lp-1:0] credit_q, credit_d;
    logic [cw_lp+1:0] sum;
    logic             tok_r, tok_primed, tok_edge;

    // The history register is only meaningful once it has sampled the token after reset.
    assign tok_edge = tok_primed & (token_i ^ tok_r);
    assign avail_o  = (credit_q != '0);

    always_comb begin
        sum        = {2'b00, credit_q} + (tok_edge ? incr_wide : '0) - (cw_lp + 2)'(issue_i);
        overflow_o = (sum > max_wide);
        credit_d   = overflow_o ? max_credit : sum[cw_lp-1:0];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credit_q   <= max_credit;
            tok_r      <= 1'b0;
            tok_primed <= 1'b0;
        end else begin
            credit_q   <= credit_d;
            tok_r      <= token_i;
            tok_primed <= 1'b1;
        end
    end

endmodule

// File: rtl/bsg_link_sdr_upstream_multi.sv
// Upstream SDR link engine: buffers one word, serializes it over lockstep channels in
// piso_ratio beats, gated by per-channel credits.
module bsg_link_sdr_upstream_multi
    import bsg_link_pkg::*;
#(
    parameter int unsigned width_p                         = 32,
    parameter int unsigned channel_width_p                 = 8,
    parameter int unsigned num_channels_p                  = 2,
    parameter int unsigned lg_fifo_depth_p                 = 6,
    parameter int unsigned lg_credit_to_token_decimation_p = 3
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,
    input  logic                                      link_enable_i,
    input  logic [width_p-1:0]                        data_i,
    input  logic                                      valid_i,
    output logic                                      ready_o,
    output logic [num_channels_p*channel_width_p-1:0] io_data_r_o,
    output logic [num_channels_p-1:0]                 io_valid_r_o,
    input  logic [num_channels_p-1:0]                 io_token_i,
    output logic                                      credit_overflow_o
);

    localparam int unsigned beat_w_lp     = num_channels_p * channel_width_p;
    localparam int unsigned piso_ratio_lp = width_p / beat_w_lp;
    localparam int unsigned bw_lp         = (piso_ratio_lp > 1) ? $clog2(piso_ratio_lp) : 1;
    localparam logic [bw_lp-1:0] last_beat = bw_lp'(piso_ratio_lp - 1);

    logic [width_p-1:0]        word_q;
    logic                      word_v_q;
    logic [bw_lp-1:0]          beat_q;
    logic                      overflow_q;
    logic [num_channels_p-1:0] avail, overflow;
    logic                      issue, last_issue, accept;
    logic [beat_w_lp-1:0]      beat_data;

    for (genvar c = 0; c < num_channels_p; c++) begin : g_ch
        bsg_link_credit_counter #(
            .lg_fifo_depth_p                (lg_fifo_depth_p),
            .lg_credit_to_token_decimation_p(lg_credit_to_token_decimation_p)
        ) u_cnt (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .token_i   (io_token_i[c]),
            .issue_i   (issue),
            .avail_o   (avail[c]),
            .overflow_o(overflow[c])
        );
    end

    // Lockstep: any starved channel holds back every channel.
    assign issue      = link_enable_i & word_v_q & (&avail);
    assign last_issue = issue & (beat_q == last_beat);
    assign ready_o    = link_enable_i & (~word_v_q | last_issue);
    assign accept     = valid_i & ready_o;

    assign credit_overflow_o = overflow_q;

    always_comb begin
        beat_data = word_q[slice_lsb(32'(beat_q), 0, num_channels_p, channel_width_p) +: beat_w_lp];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            word_q       <= '0;
            word_v_q     <= 1'b0;
            beat_q       <= '0;
            io_data_r_o  <= '0;
            io_valid_r_o <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (accept) begin
                word_q <= data_i;
            end
            if (accept) begin
                word_v_q <= 1'b1;
            end else if (last_issue) begin
                word_v_q <= 1'b0;
            end
            if (last_issue) begin
                beat_q <= '0;
            end else if (issue) begin
                beat_q <= beat_q + 1'b1;
            end
            if (issue) begin
                io_data_r_o <= beat_data;
            end
            io_valid_r_o <= issue ? '1 : '0;
            overflow_q   <= overflow_q | (|overflow);
        end
    end

endmodule

// File: tb/tb_bsg_link_sdr_upstream_multi.sv
// Directed bench for the upstream link: 32-bit words over 2x8-bit channels, 4 credits,
// +2 credits per token toggle.
module tb_bsg_link_sdr_upstream_multi;

    typedef struct {
        logic        en;
        logic        valid;
        logic [31:0] data;
        logic [1:0]  tok;
        logic        ready;
        logic [1:0]  vld;
        logic [15:0] dat;
        logic        ovf;
    } row_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        link_enable;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic [15:0] io_data;
    logic [1:0]  io_valid;
    logic [1:0]  io_token;
    logic        credit_overflow;

    int n_checks = 0;
    int n_errors = 0;

    row_t tbl[$];

    always #5 clk = ~clk;

    bsg_link_sdr_upstream_multi #(
        .width_p                        (32),
        .channel_width_p                (8),
        .num_channels_p                 (2),
        .lg_fifo_depth_p                (2),
        .lg_credit_to_token_decimation_p(1)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .link_enable_i    (link_enable),
        .data_i           (data),
        .valid_i          (valid),
        .ready_o          (ready),
        .io_data_r_o      (io_data),
        .io_valid_r_o     (io_valid),
        .io_token_i       (io_token),
        .credit_overflow_o(credit_overflow)
    );

    function automatic row_t mk(logic en, logic v, logic [31:0] d, logic [1:0] t,
                                logic rdy, logic [1:0] vl, logic [15:0] dt, logic ov);
        row_t r;
        r.en = en; r.valid = v; r.data = d; r.tok = t;
        r.ready = rdy; r.vld = vl; r.dat = dt; r.ovf = ov;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge: drive, check ready_o, clock, check registered outputs.
    task automatic apply(input row_t r, input string tag);
        link_enable = r.en;
        valid       = r.valid;
        data        = r.data;
        io_token    = r.tok;
        #1;
        check({tag, " ready"}, 32'(ready), 32'(r.ready));
        @(posedge clk);
        #1;
        check({tag, " io_valid"}, 32'(io_valid), 32'(r.vld));
        check({tag, " io_data"}, 32'(io_data), 32'(r.dat));
        check({tag, " overflow"}, 32'(credit_overflow), 32'(r.ovf));
    endtask

    initial begin
        reset_n     = 1'b0;
        link_enable = 1'b0;
        valid       = 1'b0;
        data        = '0;
        io_token    = 2'b00;

        // Words A..G serialized LSB slice first; credits 4/4 at start.
        tbl.push_back(mk(1, 1, 32'hDDCC_BBAA, 2'b00, 1, 2'b00, 16'h0000, 0));
        tbl.push_back(mk(1, 1, 32'h4433_2211, 2'b00, 0, 2'b11, 16'hBBAA, 0));
        tbl.push_back(mk(1, 1, 32'h4433_2211, 2'b00, 1, 2'b11, 16'hDDCC, 0));
        tbl.push_back(mk(1, 1, 32'h8877_6655, 2'b00, 0, 2'b11, 16'h2211, 0));
        tbl.push_back(mk(1, 1, 32'h8877_6655, 2'b00, 1, 2'b11, 16'h4433, 0));
        tbl.push_back(mk(1, 1, 32'h8877_6655, 2'b00, 0, 2'b00, 16'h4433, 0));
        tbl.push_back(mk(1, 0, 32'h0, 2'b00, 0, 2'b00, 16'h4433, 0));
        // Only channel 0 refilled: lockstep stall.
        tbl.push_back(mk(1, 0, 32'h0, 2'b01, 0, 2'b00, 16'h4433, 0));
        tbl.push_back(mk(1, 0, 32'h0, 2'b01, 0, 2'b00, 16'h4433, 0));
        tbl.push_back(mk(1, 0, 32'h0, 2'b11, 0, 2'b00, 16'h4433, 0));
        tbl.push_back(mk(1, 0, 32'h0, 2'b11, 0, 2'b11, 16'h6655, 0));
        tbl.push_back(mk(1, 0, 32'h0, 2'b11, 1, 2'b11, 16'h8877, 0));
        tbl.push_back(mk(1, 0, 32'h0, 2'b11, 1, 2'b00, 16'h8877, 0));
        tbl.push_back(mk(1, 0, 32'h0, 2'b00, 1, 2'b00, 16'h8877, 0));
        tbl.push_back(mk(1, 0, 32'h0, 2'b11, 1, 2'b00, 16'h8877, 0));
        tbl.push_back(mk(1, 1, 32'hA1B2_C3D4, 2'b11, 1, 2'b00, 16'h8877, 0));
        tbl.push_back(mk(1, 0, 32'h0, 2'b11, 0, 2'b11, 16'hC3D4, 0));
        // Issue + token on the same edge at credit 3 lands exactly on 4.
        tbl.push_back(mk(1, 0, 32'h0, 2'b00, 1, 2'b11, 16'hA1B2, 0));
        tbl.push_back(mk(1, 0, 32'h0, 2'b11, 1, 2'b00, 16'hA1B2, 1));
        // Saturated at 4: exactly four beats, then a stall.
        tbl.push_back(mk(1, 1, 32'h0F0E_0D0C, 2'b11, 1, 2'b00, 16'hA1B2, 1));
        tbl.push_back(mk(1, 1, 32'h1312_1110, 2'b11, 0, 2'b11, 16'h0D0C, 1));
        tbl.push_back(mk(1, 1, 32'h1312_1110, 2'b11, 1, 2'b11, 16'h0F0E, 1));
        tbl.push_back(mk(1, 0, 32'h0, 2'b11, 0, 2'b11, 16'h1110, 1));
        tbl.push_back(mk(1, 0, 32'h0, 2'b11, 1, 2'b11, 16'h1312, 1));
        tbl.push_back(mk(1, 1, 32'h1716_1514, 2'b11, 1, 2'b00, 16'h1312, 1));
        tbl.push_back(mk(1, 0, 32'h0, 2'b11, 0, 2'b00, 16'h1312, 1));

        #12;
        check("reset io_valid", 32'(io_valid), 32'h0);
        check("reset io_data", 32'(io_data), 32'h0);
        check("reset overflow", 32'(credit_overflow), 32'h0);
        check("reset ready disabled", 32'(ready), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // Link disabled: tokens still counted, word and beat position held.
        apply(mk(0, 0, 32'h0, 2'b00, 0, 2'b00, 16'h1312, 1), "dis tok0");
        apply(mk(0, 0, 32'h0, 2'b11, 0, 2'b00, 16'h1312, 1), "dis tok1");
        apply(mk(1, 0, 32'h0, 2'b11, 0, 2'b11, 16'h1514, 1), "en beat0");
        for (int k = 0; k < 5; k++) begin
            apply(mk(0, 0, 32'h0, 2'b11, 0, 2'b00, 16'h1514, 1), $sformatf("pause%0d", k));
        end
        apply(mk(1, 0, 32'h0, 2'b11, 1, 2'b11, 16'h1716, 1), "en beat1");

        // Reset mid-word: outputs clear asynchronously, held word is dropped.
        apply(mk(1, 1, 32'h5A5A_3C3C, 2'b11, 1, 2'b00, 16'h1716, 1), "pre-rst accept");
        apply(mk(1, 0, 32'h0, 2'b11, 0, 2'b11, 16'h3C3C, 1), "pre-rst beat0");
        #2;
        reset_n = 1'b0;
        #1;
        check("async rst io_valid", 32'(io_valid), 32'h0);
        check("async rst io_data", 32'(io_data), 32'h0);
        check("async rst overflow", 32'(credit_overflow), 32'h0);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        apply(mk(1, 1, 32'h9988_7766, 2'b11, 1, 2'b00, 16'h0000, 0), "post-rst accept");
        apply(mk(1, 1, 32'hDEAD_BEEF, 2'b11, 0, 2'b11, 16'h7766, 0), "post-rst b0");
        apply(mk(1, 1, 32'hDEAD_BEEF, 2'b11, 1, 2'b11, 16'h9988, 0), "post-rst b1");
        apply(mk(1, 1, 32'h0102_0304, 2'b11, 0, 2'b11, 16'hBEEF, 0), "post-rst b2");
        apply(mk(1, 1, 32'h0102_0304, 2'b11, 1, 2'b11, 16'hDEAD, 0), "post-rst b3");
        apply(mk(1, 0, 32'h0, 2'b11, 0, 2'b00, 16'hDEAD, 0), "post-rst starve");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
